// File: rtl/div_mse_monitor.sv
// rtl/div_mse_monitor.sv - windowed squared-error monitor for an approximate 16/8 divider.
// Optional DIV_ZERO_SKIP_EN: samples with d==0 are counted but excluded from the statistics.
module div_mse_monitor #(
  parameter int WIN_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] n,
  input  logic [7:0]  d,
  input  logic [7:0]  q,
  input  logic [7:0]  r,
  output logic        busy,
  output logic        done,
  output logic [47:0] sum_sq,
  output logic [31:0] mse,
  output logic [16:0] max_abs_err
);

  localparam int CW = WIN_LOG2 + 1;
  localparam logic [CW-1:0] WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           accept;

  logic           in_v, in_en;
  logic [15:0]    in_n;
  logic [7:0]     in_d, in_q, in_r;

  logic           s1_v, s1_en;
  logic [15:0]    s1_n;
  logic [16:0]    s1_p;

  logic           s2_v, s2_en;
  logic [16:0]    s2_abs;
  logic [31:0]    s2_sq;

  logic [47:0]    acc;
  logic [16:0]    max_r;

  logic [16:0]        p_c;
  logic signed [17:0] e_c;
  logic [16:0]        abs_c;
  logic [31:0]        sq_c;

  assign accept = in_valid && in_ready;

  // Error is carried at 18 bits signed so n - (q*d + r) can never wrap.
  always_comb begin
    p_c   = 17'(in_q) * 17'(in_d) + 17'(in_r);
    e_c   = $signed({2'b00, s1_n}) - $signed({1'b0, s1_p});
    abs_c = e_c[17] ? 17'(-e_c) : 17'(e_c);
    sq_c  = 32'(abs_c) * 32'(abs_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_v   <= 1'b0;
      in_en  <= 1'b0;
      in_n   <= '0;
      in_d   <= '0;
      in_q   <= '0;
      in_r   <= '0;
      s1_v   <= 1'b0;
      s1_en  <= 1'b0;
      s1_n   <= '0;
      s1_p   <= '0;
      s2_v   <= 1'b0;
      s2_en  <= 1'b0;
      s2_abs <= '0;
      s2_sq  <= '0;
    end else begin
      in_v <= accept;
      if (accept) begin
        in_n <= n;
        in_d <= d;
        in_q <= q;
        in_r <= r;
`ifdef DIV_ZERO_SKIP_EN
        in_en <= (d != 8'd0);
`else
        in_en <= 1'b1;
`endif
      end
      s1_v   <= in_v;
      s1_en  <= in_en;
      s1_n   <= in_n;
      s1_p   <= p_c;
      s2_v   <= s1_v;
      s2_en  <= s1_en;
      s2_abs <= abs_c;
      s2_sq  <= sq_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      acc         <= '0;
      max_r       <= '0;
      sum_sq      <= '0;
      mse         <= '0;
      max_abs_err <= '0;
    end else begin
      done <= 1'b0;
      if (s2_v && s2_en) begin
        acc <= acc + 48'(s2_sq);
        if (s2_abs > max_r) max_r <= s2_abs;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            cnt      <= '0;
            acc      <= '0;
            max_r    <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + CW'(1);
            if (cnt + CW'(1) == WIN_LEN) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Results are final once the last sample has left every stage.
          if (!(in_v || s1_v || s2_v)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            sum_sq      <= acc;
            mse         <= 32'(acc >> WIN_LOG2);
            max_abs_err <= max_r;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
